// File: rtl/pixel_filter_pipeline.sv
// Two-stage pixel filter (pass/brighten/invert/threshold) with aligned sync delay.
// Optional FRAME_STATS_EN adds a per-frame visible-pixel counter on frame_pixels.
module pixel_filter_pipeline #(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned CHANNELS    = 3,
  parameter int unsigned BRIGHT_STEP = 32,
  parameter int unsigned THRESH      = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_start,
  input  logic                      in_valid,
  input  logic [CHANNELS*PIX_W-1:0] in_pixel,
  input  logic                      in_hsync,
  input  logic                      in_vsync,
  input  logic                      in_blank_n,
  input  logic [1:0]                mode_req,
  input  logic                      bright_up,
  input  logic                      bright_down,
  output logic                      out_valid,
  output logic [CHANNELS*PIX_W-1:0] out_pixel,
  output logic                      out_hsync,
  output logic                      out_vsync,
  output logic                      out_blank_n,
  output logic [1:0]                active_mode,
  output logic [2:0]                bright_level
`ifdef FRAME_STATS_EN
  ,
  output logic [19:0]               frame_pixels
`endif
);

  localparam int unsigned EXT_W = PIX_W + 3;
  localparam logic [PIX_W-1:0] MAX = '1;
  localparam logic [EXT_W-1:0] MAX_EXT = EXT_W'(MAX);
  localparam logic [PIX_W-1:0] THRESH_P = PIX_W'(THRESH);

  logic [2:0]                pending_level_q, pending_level_d;
  logic [1:0]                pending_mode_q;
  logic [1:0]                active_mode_q;
  logic [2:0]                bright_level_q;
  logic [CHANNELS*EXT_W-1:0] s1_pixel_q, s1_pixel_d;
  logic                      s1_valid_q, s1_hsync_q, s1_vsync_q, s1_blank_n_q;
  logic [CHANNELS*PIX_W-1:0] out_pixel_q, out_pixel_d;
  logic                      out_valid_q, out_hsync_q, out_vsync_q, out_blank_n_q;
  logic [EXT_W-1:0]          bright_add;

  always_comb begin
    pending_level_d = pending_level_q;
    if (bright_up && !bright_down && pending_level_q != 3'd7) begin
      pending_level_d = pending_level_q + 3'd1;
    end else if (bright_down && !bright_up && pending_level_q != 3'd0) begin
      pending_level_d = pending_level_q - 3'd1;
    end
  end

  // Stage 1: per-channel arithmetic in widened form, saturation deferred to stage 2
  always_comb begin
    logic [PIX_W-1:0] p;
    bright_add = EXT_W'(32'(bright_level_q) * BRIGHT_STEP);
    s1_pixel_d = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      p = in_pixel[c*PIX_W +: PIX_W];
      unique case (active_mode_q)
        2'd0: s1_pixel_d[c*EXT_W +: EXT_W] = EXT_W'(p);
        2'd1: s1_pixel_d[c*EXT_W +: EXT_W] = EXT_W'(p) + bright_add;
        2'd2: s1_pixel_d[c*EXT_W +: EXT_W] = EXT_W'(MAX - p);
        2'd3: s1_pixel_d[c*EXT_W +: EXT_W] = (p >= THRESH_P) ? MAX_EXT : '0;
        default: s1_pixel_d[c*EXT_W +: EXT_W] = '0;
      endcase
    end
  end

  always_comb begin
    logic [EXT_W-1:0] v;
    out_pixel_d = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      v = s1_pixel_q[c*EXT_W +: EXT_W];
      if (s1_valid_q && s1_blank_n_q) begin
        out_pixel_d[c*PIX_W +: PIX_W] = (v > MAX_EXT) ? MAX : v[PIX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_level_q <= '0;
      pending_mode_q  <= '0;
      active_mode_q   <= '0;
      bright_level_q  <= '0;
      s1_pixel_q      <= '0;
      s1_valid_q      <= 1'b0;
      s1_hsync_q      <= 1'b1;
      s1_vsync_q      <= 1'b1;
      s1_blank_n_q    <= 1'b0;
      out_pixel_q     <= '0;
      out_valid_q     <= 1'b0;
      out_hsync_q     <= 1'b1;
      out_vsync_q     <= 1'b1;
      out_blank_n_q   <= 1'b0;
    end else begin
      pending_level_q <= pending_level_d;
      pending_mode_q  <= mode_req;
      // Applied values come from the pending regs as they stood before this edge
      if (frame_start) begin
        active_mode_q  <= pending_mode_q;
        bright_level_q <= pending_level_q;
      end
      s1_pixel_q    <= s1_pixel_d;
      s1_valid_q    <= in_valid;
      s1_hsync_q    <= in_hsync;
      s1_vsync_q    <= in_vsync;
      s1_blank_n_q  <= in_blank_n;
      out_pixel_q   <= out_pixel_d;
      out_valid_q   <= s1_valid_q;
      out_hsync_q   <= s1_hsync_q;
      out_vsync_q   <= s1_vsync_q;
      out_blank_n_q <= s1_blank_n_q;
    end
  end

  assign out_pixel    = out_pixel_q;
  assign out_valid    = out_valid_q;
  assign out_hsync    = out_hsync_q;
  assign out_vsync    = out_vsync_q;
  assign out_blank_n  = out_blank_n_q;
  assign active_mode  = active_mode_q;
  assign bright_level = bright_level_q;

`ifdef FRAME_STATS_EN
  logic [19:0] pix_cnt_q, pix_cnt_inc;
  logic [19:0] frame_pixels_q;

  always_comb begin
    pix_cnt_inc = pix_cnt_q;
    if (in_valid && in_blank_n && pix_cnt_q != 20'hFFFFF) begin
      pix_cnt_inc = pix_cnt_q + 20'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt_q      <= '0;
      frame_pixels_q <= '0;
    end else if (frame_start) begin
      frame_pixels_q <= pix_cnt_inc;
      pix_cnt_q      <= '0;
    end else begin
      pix_cnt_q <= pix_cnt_inc;
    end
  end

  assign frame_pixels = frame_pixels_q;
`endif

endmodule

// File: tb/tb_pixel_filter_pipeline.sv
// Directed self-checking bench for pixel_filter_pipeline (RGB, 8 bits per channel).
module tb_pixel_filter_pipeline;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic        in_valid;
  logic [23:0] in_pixel;
  logic        in_hsync, in_vsync, in_blank_n;
  logic [1:0]  mode_req;
  logic        bright_up, bright_down;
  logic        out_valid;
  logic [23:0] out_pixel;
  logic        out_hsync, out_vsync, out_blank_n;
  logic [1:0]  active_mode;
  logic [2:0]  bright_level;
`ifdef FRAME_STATS_EN
  logic [19:0] frame_pixels;
`endif

  int checks = 0;
  int failures = 0;

  pixel_filter_pipeline dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .in_hsync    (in_hsync),
    .in_vsync    (in_vsync),
    .in_blank_n  (in_blank_n),
    .mode_req    (mode_req),
    .bright_up   (bright_up),
    .bright_down (bright_down),
    .out_valid   (out_valid),
    .out_pixel   (out_pixel),
    .out_hsync   (out_hsync),
    .out_vsync   (out_vsync),
    .out_blank_n (out_blank_n),
    .active_mode (active_mode),
    .bright_level(bright_level)
`ifdef FRAME_STATS_EN
    ,
    .frame_pixels(frame_pixels)
`endif
  );

  always #5 clk = ~clk;

  // Drive one pixel cycle then one idle cycle; returns when that pixel is at the outputs
  task automatic push(input logic [23:0] p, input logic v, input logic b);
    @(negedge clk);
    in_pixel = p; in_valid = v; in_blank_n = b; in_hsync = 1'b0; in_vsync = 1'b0;
    @(negedge clk);
    in_pixel = '0; in_valid = 1'b0; in_blank_n = 1'b0; in_hsync = 1'b1; in_vsync = 1'b1;
    @(negedge clk);
  endtask

  task automatic frame(input logic [1:0] m);
    @(negedge clk);
    mode_req = m;
    @(negedge clk);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse(input logic up, input logic dn);
    @(negedge clk);
    bright_up = up; bright_down = dn;
    @(negedge clk);
    bright_up = 1'b0; bright_down = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; frame_start = 0; in_valid = 0; in_pixel = '0; in_hsync = 1; in_vsync = 1;
    in_blank_n = 0; mode_req = 0; bright_up = 0; bright_down = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_pixel, out_valid, out_blank_n, out_hsync, out_vsync, active_mode, bright_level}
        !== {24'h0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_state got pix=%h v=%b bn=%b hs=%b vs=%b m=%0d l=%0d", out_pixel,
               out_valid, out_blank_n, out_hsync, out_vsync, active_mode, bright_level);
    end
    reset = 1'b0;
  endtask

  task automatic test_pass;
    @(negedge clk);
    in_pixel = 24'h102030; in_valid = 1; in_blank_n = 1; in_hsync = 0; in_vsync = 1;
    @(negedge clk);
    in_pixel = '0; in_valid = 0; in_blank_n = 0; in_hsync = 1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL pass_latency1 got valid=%b exp 0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_pixel, out_valid, out_blank_n, out_hsync} !== {24'h102030, 3'b110}) begin
      failures++;
      $display("FAIL pass_out got %h v=%b bn=%b hs=%b exp 102030 1 1 0", out_pixel, out_valid,
               out_blank_n, out_hsync);
    end
  endtask

  task automatic test_brighten;
    repeat (3) pulse(1, 0);
    frame(2'd1);
    checks++;
    if ({active_mode, bright_level} !== {2'd1, 3'd3}) begin
      failures++; $display("FAIL bright_apply got m=%0d l=%0d exp 1 3", active_mode, bright_level);
    end
    push(24'h10F0A0, 1, 1);
    checks++;
    if (out_pixel !== 24'h70FFFF) begin
      failures++; $display("FAIL bright_sat got %h exp 70ffff", out_pixel);
    end
  endtask

  task automatic test_invert_thresh;
    frame(2'd2);
    push(24'h7F80FF, 1, 1);
    checks++;
    if (out_pixel !== 24'h807F00) begin
      failures++; $display("FAIL invert got %h exp 807f00", out_pixel);
    end
    frame(2'd3);
    push(24'h7F80FF, 1, 1);
    checks++;
    if (out_pixel !== 24'h00FFFF) begin
      failures++; $display("FAIL threshold got %h exp 00ffff", out_pixel);
    end
  endtask

  task automatic test_mode_hold;
    @(negedge clk);
    mode_req = 2'd1;
    repeat (3) @(negedge clk);
    push(24'h7F80FF, 1, 1);
    checks++;
    if (out_pixel !== 24'h00FFFF || active_mode !== 2'd3) begin
      failures++;
      $display("FAIL mode_hold got %h m=%0d exp 00ffff 3", out_pixel, active_mode);
    end
    frame(2'd1);
    push(24'h10F0A0, 1, 1);
    checks++;
    if (out_pixel !== 24'h70FFFF || active_mode !== 2'd1) begin
      failures++;
      $display("FAIL mode_apply got %h m=%0d exp 70ffff 1", out_pixel, active_mode);
    end
  endtask

  task automatic test_blank;
    push(24'h123456, 1, 0);
    checks++;
    if ({out_pixel, out_valid, out_blank_n} !== {24'h0, 2'b10}) begin
      failures++;
      $display("FAIL blanked got %h v=%b bn=%b exp 0 1 0", out_pixel, out_valid, out_blank_n);
    end
    push(24'h123456, 0, 1);
    checks++;
    if ({out_pixel, out_valid, out_blank_n} !== {24'h0, 2'b01}) begin
      failures++;
      $display("FAIL invalid got %h v=%b bn=%b exp 0 0 1", out_pixel, out_valid, out_blank_n);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] vec [4] = '{24'h010203, 24'hA0B0C0, 24'hFFFFFF, 24'h000001};
    frame(2'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (out_pixel !== vec[i-2] || out_valid !== 1'b1) begin
          failures++;
          $display("FAIL b2b_%0d got %h v=%b exp %h 1", i - 2, out_pixel, out_valid, vec[i-2]);
        end
      end
      if (i < 4) begin
        in_pixel = vec[i]; in_valid = 1; in_blank_n = 1;
      end else begin
        in_pixel = '0; in_valid = 0; in_blank_n = 0;
      end
    end
  endtask

  task automatic test_level_sat;
    repeat (9) pulse(1, 0);
    frame(2'd1);
    checks++;
    if (bright_level !== 3'd7) begin
      failures++; $display("FAIL level_max got %0d exp 7", bright_level);
    end
    pulse(0, 1);
    pulse(1, 1);
    frame(2'd1);
    checks++;
    if (bright_level !== 3'd6) begin
      failures++; $display("FAIL level_updown got %0d exp 6", bright_level);
    end
    // bright_up coincident with frame_start lands one frame later
    @(negedge clk);
    frame_start = 1; bright_up = 1;
    @(negedge clk);
    frame_start = 0; bright_up = 0;
    checks++;
    if (bright_level !== 3'd6) begin
      failures++; $display("FAIL level_same_cycle got %0d exp 6", bright_level);
    end
    frame(2'd1);
    checks++;
    if (bright_level !== 3'd7) begin
      failures++; $display("FAIL level_next_frame got %0d exp 7", bright_level);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    in_pixel = 24'h101010; in_valid = 1; in_blank_n = 1; in_hsync = 0; in_vsync = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (out_pixel !== 24'hF0F0F0) begin
      failures++; $display("FAIL pre_reset got %h exp f0f0f0", out_pixel);
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({out_pixel, out_valid, out_hsync, out_vsync, active_mode, bright_level}
        !== {24'h0, 3'b011, 2'd0, 3'd0}) begin
      failures++;
      $display("FAIL reset_mid got %h v=%b hs=%b vs=%b m=%0d l=%0d exp 0 0 1 1 0 0", out_pixel,
               out_valid, out_hsync, out_vsync, active_mode, bright_level);
    end
    @(negedge clk);
    in_pixel = '0; in_valid = 0; in_blank_n = 0; in_hsync = 1; in_vsync = 1; mode_req = 0;
    reset = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_pixel, out_valid, out_blank_n} !== {24'h0, 2'b00}) begin
      failures++; $display("FAIL post_reset got %h v=%b bn=%b exp 0 0 0", out_pixel, out_valid,
                           out_blank_n);
    end
    pulse(0, 1);
    frame(2'd2);
    checks++;
    if ({active_mode, bright_level} !== {2'd2, 3'd0}) begin
      failures++;
      $display("FAIL level_min got m=%0d l=%0d exp 2 0", active_mode, bright_level);
    end
  endtask

`ifdef FRAME_STATS_EN
  task automatic test_frame_stats;
    frame(2'd0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in_valid = 1; in_blank_n = (i < 50); in_pixel = 24'h000010;
    end
    @(negedge clk);
    in_blank_n = 1; frame_start = 1;
    @(negedge clk);
    in_valid = 0; in_blank_n = 0; frame_start = 0;
    checks++;
    if (frame_pixels !== 20'd51) begin
      failures++; $display("FAIL frame_pixels got %0d exp 51", frame_pixels);
    end
    frame(2'd0);
    checks++;
    if (frame_pixels !== 20'd0) begin
      failures++; $display("FAIL frame_pixels_empty got %0d exp 0", frame_pixels);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_pass();
    test_brighten();
    test_invert_thresh();
    test_mode_hold();
    test_blank();
    test_back_to_back();
    test_level_sat();
    test_reset_mid();
`ifdef FRAME_STATS_EN
    test_frame_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
